uart_rx: RTL
============

# uart_rx

Serial UART receiver that consumes the 8x-oversampling baud enable (`rx_bd_en`) from the shared baud-rate generator and recovers 8N1-style frames from the `rxd` line. It synchronizes the asynchronous input, qualifies the start bit, and majority-votes three mid-bit samples per bit. It presents each completed byte with a one-cycle valid pulse plus error flags. It sits between the pad and the UART host-side logic, mirroring the transmitter on the other end of the link.

## Interface
- `DATA_BITS`, default 8: data bits per frame, 5..8, LSB first.
- `PARITY_EN`, default 0: 1 = a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `clk`  in  1  system clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `rx_bd_en`  in  1  one-`clk` pulse at 8x baud rate; all bit timing advances only on this pulse.
- `rxd`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  DATA_BITS  last received data word; updated only at frame completion.
- `rx_valid`  out  1  one-`clk` pulse, frame completed.
- `frame_err`  out  1  stop-bit vote was 0 for the last frame; valid with `rx_valid`, held until the next `rx_valid`.
- `parity_err`  out  1  parity mismatch for the last frame; always 0 when `PARITY_EN`=0; held like `frame_err`.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Input sync: 2-flop synchronizer on `rxd` produces `rxd_s`. Both flops reset to 1.
- Tick counter `cnt[2:0]` advances by 1 (mod 8) on each `rx_bd_en` outside IDLE.
- Sample points: the value of `rxd_s` at ticks where `cnt`=3, 4, 5, taken before the increment.
- Vote: the bit value is the majority of the three samples, evaluated on the `cnt`=5 tick.
- States:
  - IDLE: on an `rx_bd_en` tick with `rxd_s`=0, go to START with `cnt`<=1. Ignore `rxd_s` between ticks.
  - START: on the `cnt`=5 tick, vote=1 means a false start and the block returns to IDLE immediately. Vote=0 means it continues. On the `cnt`=7 tick, go to DATA with bit index 0.
  - DATA: on each `cnt`=5 tick, shift the vote into the shift register, LSB first. On the `cnt`=7 tick after bit DATA_BITS-1, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: on the `cnt`=5 tick, latch the vote. `parity_err` = XOR of the data bits, the parity bit and `PARITY_ODD`, which is nonzero on mismatch. On the `cnt`=7 tick, go to STOP.
  - STOP: on the `cnt`=5 tick, do all of the following on that same tick:
    - load `rx_data` from the shift register;
    - pulse `rx_valid`;
    - set `frame_err` = ~vote;
    - update `parity_err`;
    - go to IDLE.
- Leaving STOP at tick 5 gives about 3 ticks of margin to catch a back-to-back start bit.
- A frame with a stop error is still delivered; `rx_data` holds the received bits.
- No FIFO. The consumer must take `rx_data` before the next `rx_valid`, about 8×(frame bits) ticks later.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `rx_busy`=0, state IDLE, `cnt`=0, sync flops=1.
- Asserting `rst` mid-frame aborts the frame with no `rx_valid`. After release, the block waits in IDLE for a new falling edge seen on a tick.
- Input latency: 2 `clk` of synchronizer, plus up to 1 tick of start-detect quantization.
- `rx_valid` goes high the `clk` after the STOP `cnt`=5 tick and lasts exactly 1 `clk`. `rx_data` and the error flags are stable from that edge.
- `rx_busy` rises the `clk` after the start-detect tick. It falls in the same cycle that `rx_valid` rises, or the `clk` after a false-start tick.
- Ticks are assumed at least 3 `clk` apart. Behaviour between ticks is hold-only.
- A single-sample glitch inside a bit is rejected by the vote. A low pulse shorter than 2 samples at start is rejected as a false start.

## Test plan
- Basic byte: bench drives `rx_bd_en` every 4 `clk` (1 bit = 8 ticks), defaults, frame 0xA5 -> exactly one `rx_valid` with `rx_data`=0xA5, `frame_err`=0, `parity_err`=0, and `rx_busy` low afterwards.
- False start: `rxd` low for 2 ticks, then high -> no `rx_valid`, `rx_busy` back to 0 before tick 7, and a following frame 0x3C is received correctly.
- Glitch rejection: frame 0x00 with `rxd` forced high for exactly 1 tick at `cnt`=4 of data bit 2 -> `rx_data`=0x00.
- Errors: frame 0x81 with stop bit held 0 -> `rx_valid`, `rx_data`=0x81, `frame_err`=1. With `PARITY_EN`=1, `PARITY_ODD`=0, frame 0x03 sent with parity bit 1 -> `parity_err`=1, `frame_err`=0. Next good frame -> both flags clear.
- Back-to-back: 0x55 immediately followed by 0xAA with 1 stop bit and no idle gap -> two `rx_valid` pulses with the correct data, in order.
- Reset mid-frame: assert `rst` during data bit 4 of 0xFF -> all outputs 0 at once, no `rx_valid`. Next frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: received word, strobe, flags.
// The receiver drives it (master); host logic consumes it (slave).
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input parity_err,
    input rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8x-oversampled, 3-sample majority vote per bit,
// optional parity, one-cycle valid strobe with frame/parity flags.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_bd_en,
  input  logic      rxd,
  uart_rx_if.master rx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;

  logic                 sync1;
  logic                 rxd_s;
  logic [2:0]           cnt;
  logic [2:0]           bit_idx;
  logic                 s3;
  logic                 s4;
  logic                 par_bit;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 fe_q;
  logic                 pe_q;
  logic                 vote;
  logic                 mid;
  logic                 last;
  logic                 bit_last;

  assign vote = (s3 & s4) | (s3 & rxd_s) | (s4 & rxd_s);
  assign mid = rx_bd_en && (cnt == 3'd5);
  assign last = rx_bd_en && (cnt == 3'd7);
  assign bit_last = (bit_idx == 3'(DATA_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (rx_bd_en && !rxd_s) state_n = START;
      START:
        if (mid && vote) state_n = IDLE;
        else if (last)   state_n = DATA;
      DATA:
        if (last && bit_last)
          state_n = PARITY_EN ? PARITY : STOP;
      PARITY:
        if (last) state_n = STOP;
      STOP:
        if (mid) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 3'd0;
      bit_idx <= 3'd0;
      s3      <= 1'b0;
      s4      <= 1'b0;
      par_bit <= 1'b0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rx_bd_en) begin
        // Start detect lands on tick 1 so the vote straddles mid-bit
        if (state == IDLE)
          cnt <= rxd_s ? 3'd0 : 3'd1;
        else if (state_n == IDLE)
          cnt <= 3'd0;
        else
          cnt <= cnt + 3'd1;
        if (cnt == 3'd3) s3 <= rxd_s;
        if (cnt == 3'd4) s4 <= rxd_s;
      end
      if (state == START)
        bit_idx <= 3'd0;
      else if (state == DATA && last)
        bit_idx <= bit_idx + 3'd1;
      if (state == DATA && mid)
        shreg <= {vote, shreg[DATA_BITS-1:1]};
      if (state == PARITY && mid)
        par_bit <= vote;
      if (state == STOP && mid) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
        fe_q    <= ~vote;
        pe_q    <= PARITY_EN ? (^shreg ^ par_bit ^ PARITY_ODD) : 1'b0;
      end
    end
  end

  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.frame_err  = fe_q;
  assign rx.parity_err = pe_q;
  assign rx.rx_busy    = (state != IDLE);

endmodule
